// File: rtl/prog_data_mem_pkg.sv
// Shared definitions for the processor memory.
// Covers the boot FSM states, lane-width derivation and the byte-extension helper.
package prog_data_mem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } boot_state_t;

  function automatic int lanes_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int lsb_w_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Fill bit for the upper part of a byte read: copies bit 7 only when signed.
  function automatic logic ext_fill(input logic [7:0] b, input logic sgn);
    return sgn & b[7];
  endfunction

endpackage

// File: rtl/prog_data_mem_if.sv
// Boot-load, instruction-fetch and load/store signals of the processor memory.
// The host/datapath side uses master; the memory uses slave.
interface prog_data_mem_if
  import prog_data_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  localparam int LSB_W = lsb_w_of(DATA_W);

  logic                     load_valid;
  logic [DATA_W-1:0]        load_data;
  logic                     load_last;
  logic                     load_ready;
  logic                     boot_done;
  logic                     i_req;
  logic [ADDR_W-1:0]        i_addr;
  logic [DATA_W-1:0]        i_data;
  logic                     i_valid;
  logic                     d_re;
  logic                     d_we;
  logic                     d_byte;
  logic                     d_signed;
  logic [ADDR_W+LSB_W-1:0]  d_addr;
  logic [DATA_W-1:0]        d_wdata;
  logic [DATA_W-1:0]        d_rdata;
  logic                     d_valid;

  modport master (
    output load_valid, load_data, load_last, i_req, i_addr,
           d_re, d_we, d_byte, d_signed, d_addr, d_wdata,
    input  load_ready, boot_done, i_data, i_valid, d_rdata, d_valid
  );

  modport slave (
    input  load_valid, load_data, load_last, i_req, i_addr,
           d_re, d_we, d_byte, d_signed, d_addr, d_wdata,
    output load_ready, boot_done, i_data, i_valid, d_rdata, d_valid
  );

endinterface

// File: rtl/prog_data_mem_boot_fsm.sv
// Boot sequencer: optional zero-fill, streamed program load, then run.
// It owns the single write port and selects between clear, load and datapath writes.
module mem_boot_fsm
  import prog_data_mem_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 6,
  parameter int CLEAR_ON_RESET = 1,
  localparam int LANES         = lanes_of(DATA_W),
  localparam int LSB_W         = lsb_w_of(DATA_W)
) (
  input  logic              clk,
  input  logic              proc_rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              boot_done,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_word,
  input  logic [LSB_W-1:0]  d_lane,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              run,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [LANES-1:0]  wr_mask
);

  localparam boot_state_t      START     = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_LOAD;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  boot_state_t       state, state_next;
  logic [ADDR_W-1:0] cnt, cnt_next;
  logic              accept;
  logic [LANES-1:0]  lane_onehot;

  assign accept      = (state == ST_LOAD) && load_ready && load_valid;
  assign lane_onehot = LANES'(1) << d_lane;
  assign run         = (state == ST_RUN);

  // Handshake flags are registered from the next state so they are low straight out of reset.
  always_ff @(posedge clk) begin
    if (proc_rst) begin
      state      <= START;
      cnt        <= '0;
      load_ready <= 1'b0;
      boot_done  <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      load_ready <= (state_next == ST_LOAD);
      boot_done  <= (state_next == ST_RUN);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    wr_en      = 1'b0;
    wr_addr    = cnt;
    wr_data    = '0;
    wr_mask    = '1;
    case (state)
      ST_CLEAR: begin
        wr_en    = 1'b1;
        cnt_next = cnt + 1'b1;
        if (cnt == LAST_ADDR) begin
          state_next = ST_LOAD;
          cnt_next   = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wr_en    = 1'b1;
          wr_data  = load_data;
          cnt_next = cnt + 1'b1;
          // A full image ends the load even without load_last; the counter never wraps.
          if (load_last || (cnt == LAST_ADDR)) begin
            state_next = ST_RUN;
            cnt_next   = cnt;
          end
        end
      end
      ST_RUN: begin
        wr_en   = d_we;
        wr_addr = d_word;
        if (d_byte) begin
          wr_data = {LANES{d_wdata[7:0]}};
          wr_mask = lane_onehot;
        end else begin
          wr_data = d_wdata;
        end
      end
      default: begin
        state_next = START;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/prog_data_mem.sv
// Processor memory with a read-only fetch port and a word/byte load-store port.
// Contents are written by the boot sequencer, then by the datapath once running.
module prog_data_mem
  import prog_data_mem_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 6,
  parameter int CLEAR_ON_RESET = 1,
  localparam int LANES         = lanes_of(DATA_W),
  localparam int LSB_W         = lsb_w_of(DATA_W),
  localparam int DEPTH         = 2 ** ADDR_W
) (
  input  logic          clk,
  input  logic          proc_rst,
  prog_data_mem_if.slave bus
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [LANES-1:0]  wr_mask;
  logic [ADDR_W-1:0] d_word;
  logic [LSB_W-1:0]  d_lane;
  logic [DATA_W-1:0] word_rd;
  logic [7:0]        byte_rd;
  logic [DATA_W-1:0] byte_ext;

  assign d_word   = bus.d_addr[ADDR_W+LSB_W-1:LSB_W];
  assign d_lane   = bus.d_addr[LSB_W-1:0];
  assign word_rd  = mem[d_word];
  assign byte_rd  = word_rd[{d_lane, 3'b000} +: 8];
  assign byte_ext = {{(DATA_W-8){ext_fill(byte_rd, bus.d_signed)}}, byte_rd};

  mem_boot_fsm #(
    .DATA_W         (DATA_W),
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_boot (
    .clk        (clk),
    .proc_rst   (proc_rst),
    .load_valid (bus.load_valid),
    .load_data  (bus.load_data),
    .load_last  (bus.load_last),
    .load_ready (bus.load_ready),
    .boot_done  (bus.boot_done),
    .d_we       (bus.d_we),
    .d_byte     (bus.d_byte),
    .d_word     (d_word),
    .d_lane     (d_lane),
    .d_wdata    (bus.d_wdata),
    .run        (run),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_mask    (wr_mask)
  );

  // Storage is not reset; the boot sequence is what gives it defined contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (wr_mask[l]) mem[wr_addr][l*8 +: 8] <= wr_data[l*8 +: 8];
      end
    end
  end

  // Both read ports sample the array before this edge's write lands (read-before-write).
  always_ff @(posedge clk) begin
    if (proc_rst) begin
      bus.i_data  <= '0;
      bus.i_valid <= 1'b0;
      bus.d_rdata <= '0;
      bus.d_valid <= 1'b0;
    end else begin
      bus.i_valid <= run && bus.i_req;
      bus.d_valid <= run && bus.d_re;
      if (run && bus.i_req) bus.i_data <= mem[bus.i_addr];
      if (run && bus.d_re) bus.d_rdata <= bus.d_byte ? byte_ext : word_rd;
    end
  end

endmodule

// File: tb/tb_prog_data_mem.sv
// Self-checking bench for prog_data_mem (16-bit words, 64 deep, clear on reset).
// Read expectations come from a reference memory and are queued when the request is driven.
module tb_prog_data_mem;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic clk = 1'b0;
  logic proc_rst = 1'b0;

  prog_data_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  prog_data_mem #(
    .DATA_W         (DATA_W),
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk      (clk),
    .proc_rst (proc_rst),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] model [DEPTH];
  logic [15:0] i_q [$];
  logic [15:0] d_q [$];
  logic [15:0] last_i = '0;
  logic [15:0] last_d = '0;

  typedef struct {
    logic        we;
    logic        re;
    logic        byt;
    logic        sgn;
    logic [6:0]  addr;
    logic [15:0] wdata;
  } dop_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_re = 1'b0; bus.d_we = 1'b0; bus.d_byte = 1'b0; bus.d_signed = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic clear_model();
    for (int k = 0; k < DEPTH; k++) model[k] = '0;
    last_i = '0;
    last_d = '0;
  endtask

  function automatic logic [15:0] model_read(input logic [6:0] a, input logic byt, input logic sgn);
    logic [15:0] w;
    logic [7:0]  b;
    w = model[a[6:1]];
    if (!byt) return w;
    b = a[0] ? w[15:8] : w[7:0];
    return (sgn && b[7]) ? {8'hFF, b} : {8'h00, b};
  endfunction

  task automatic model_write(input logic [6:0] a, input logic byt, input logic [15:0] wd);
    if (!byt) model[a[6:1]] = wd;
    else if (a[0]) model[a[6:1]][15:8] = wd[7:0];
    else model[a[6:1]][7:0] = wd[7:0];
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (bus.load_ready !== 1'b1 && cycles < 200) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    int   cycles;
    logic saw_valid;
    idle_inputs();
    bus.i_req = 1'b1; bus.d_re = 1'b1;
    proc_rst = 1'b1;
    step();
    proc_rst = 1'b0;
    n_checks++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_load_ready: got %b, expected 0", bus.load_ready); end
    n_checks++; if (bus.boot_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_boot_done: got %b, expected 0", bus.boot_done); end
    n_checks++; if (bus.i_valid !== 1'b0 || bus.d_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valids: got i=%b d=%b, expected 0 0", bus.i_valid, bus.d_valid); end
    n_checks++; if (bus.i_data !== 16'h0 || bus.d_rdata !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_data: got i=%h d=%h, expected 0000 0000", bus.i_data, bus.d_rdata); end
    clear_model();
    // Requests and writes during the clear phase must be ignored.
    bus.d_we = 1'b1; bus.d_addr = 7'd20; bus.d_wdata = 16'hBEEF;
    cycles = 0; saw_valid = 1'b0;
    while (bus.load_ready !== 1'b1 && cycles < 200) begin
      step();
      cycles++;
      if (bus.i_valid !== 1'b0 || bus.d_valid !== 1'b0) saw_valid = 1'b1;
    end
    n_checks++; if (cycles != 64) begin n_fail++; $display("[TB] FAIL clear_length: got %0d cycles, expected 64", cycles); end
    n_checks++; if (saw_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_valids: got valid during clear, expected none"); end
  endtask

  task automatic test_load();
    bus.i_req = 1'b1; bus.i_addr = 6'd0;
    bus.load_valid = 1'b1; bus.load_data = 16'h8000; bus.load_last = 1'b0;
    step();
    model[0] = 16'h8000;
    n_checks++; if (bus.i_valid !== 1'b0 || bus.d_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL load_valids: got i=%b d=%b, expected 0 0", bus.i_valid, bus.d_valid); end
    bus.load_data = 16'h4123; bus.load_last = 1'b1;
    step();
    model[1] = 16'h4123;
    idle_inputs();
    n_checks++; if (bus.boot_done !== 1'b1) begin n_fail++; $display("[TB] FAIL boot_done: got %b, expected 1", bus.boot_done); end
    n_checks++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL run_load_ready: got %b, expected 0", bus.load_ready); end
    // Extra boot words in RUN must not land in word 2.
    bus.load_valid = 1'b1; bus.load_data = 16'h7777;
    step();
    idle_inputs();
  endtask

  task automatic test_ifetch();
    logic [5:0]  addrs [5];
    logic [15:0] exp;
    addrs = '{6'd1, 6'd5, 6'd0, 6'd2, 6'd10};
    for (int k = 0; k < 5; k++) begin
      bus.i_req = 1'b1; bus.i_addr = addrs[k];
      i_q.push_back(model[addrs[k]]);
      bus.d_re = 1'b1; bus.d_byte = 1'b0; bus.d_addr = {addrs[4 - k], 1'b1};
      d_q.push_back(model_read({addrs[4 - k], 1'b1}, 1'b0, 1'b0));
      step();
      exp = i_q.pop_front(); last_i = exp;
      n_checks++; if (bus.i_valid !== 1'b1 || bus.i_data !== exp) begin n_fail++; $display("[TB] FAIL ifetch_%0d: got v=%b %h, expected v=1 %h", addrs[k], bus.i_valid, bus.i_data, exp); end
      exp = d_q.pop_front(); last_d = exp;
      n_checks++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== exp) begin n_fail++; $display("[TB] FAIL dword_%0d: got v=%b %h, expected v=1 %h", addrs[4 - k], bus.d_valid, bus.d_rdata, exp); end
    end
    idle_inputs();
  endtask

  task automatic run_dops(input string tag, input dop_t ops [$]);
    logic [15:0] exp;
    foreach (ops[k]) begin
      bus.d_we = ops[k].we; bus.d_re = ops[k].re; bus.d_byte = ops[k].byt;
      bus.d_signed = ops[k].sgn; bus.d_addr = ops[k].addr; bus.d_wdata = ops[k].wdata;
      if (ops[k].re) d_q.push_back(model_read(ops[k].addr, ops[k].byt, ops[k].sgn));
      if (ops[k].we) model_write(ops[k].addr, ops[k].byt, ops[k].wdata);
      step();
      if (ops[k].re) begin
        exp = d_q.pop_front(); last_d = exp;
        n_checks++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== exp) begin n_fail++; $display("[TB] FAIL %s_op%0d: got v=%b %h, expected v=1 %h", tag, k, bus.d_valid, bus.d_rdata, exp); end
      end else begin
        n_checks++; if (bus.d_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL %s_op%0d_valid: got %b, expected 0", tag, k, bus.d_valid); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_byte();
    dop_t ops [$];
    ops = '{
      '{1'b1, 1'b0, 1'b0, 1'b0, 7'd6, 16'h12F4},
      '{1'b0, 1'b1, 1'b1, 1'b1, 7'd6, 16'h0000},
      '{1'b0, 1'b1, 1'b1, 1'b0, 7'd6, 16'h0000},
      '{1'b0, 1'b1, 1'b1, 1'b0, 7'd7, 16'h0000},
      '{1'b0, 1'b1, 1'b1, 1'b1, 7'd7, 16'h0000},
      '{1'b1, 1'b0, 1'b1, 1'b0, 7'd7, 16'h99AB},
      '{1'b0, 1'b1, 1'b0, 1'b0, 7'd7, 16'h0000},
      '{1'b1, 1'b0, 1'b1, 1'b0, 7'd6, 16'h3380},
      '{1'b0, 1'b1, 1'b1, 1'b1, 7'd6, 16'h0000},
      '{1'b0, 1'b1, 1'b0, 1'b0, 7'd6, 16'h0000}
    };
    run_dops("byte", ops);
    n_checks++; if (model[3] !== 16'hAB80) begin n_fail++; $display("[TB] FAIL byte_model: got %h, expected AB80", model[3]); end
  endtask

  task automatic test_collision();
    logic [15:0] exp;
    dop_t ops [$];
    bus.d_we = 1'b1; bus.d_addr = 7'd4; bus.d_wdata = 16'h1111;
    model[2] = 16'h1111;
    step();
    for (int k = 0; k < 2; k++) begin
      bus.d_we = (k == 0); bus.d_wdata = 16'h5555; bus.d_re = 1'b1; bus.d_byte = 1'b0; bus.d_addr = 7'd4;
      bus.i_req = 1'b1; bus.i_addr = 6'd2;
      i_q.push_back(model[2]);
      d_q.push_back(model[2]);
      if (k == 0) model[2] = 16'h5555;
      step();
      exp = i_q.pop_front(); last_i = exp;
      n_checks++; if (bus.i_valid !== 1'b1 || bus.i_data !== exp) begin n_fail++; $display("[TB] FAIL collide_i_%0d: got v=%b %h, expected v=1 %h", k, bus.i_valid, bus.i_data, exp); end
      exp = d_q.pop_front(); last_d = exp;
      n_checks++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== exp) begin n_fail++; $display("[TB] FAIL collide_d_%0d: got v=%b %h, expected v=1 %h", k, bus.d_valid, bus.d_rdata, exp); end
    end
    idle_inputs();
    ops = '{
      '{1'b1, 1'b1, 1'b1, 1'b0, 7'd5, 16'h00AA},
      '{1'b0, 1'b1, 1'b0, 1'b0, 7'd4, 16'h0000}
    };
    run_dops("collide_byte", ops);
  endtask

  task automatic test_idle();
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++; if (bus.i_valid !== 1'b0 || bus.d_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_valids_%0d: got i=%b d=%b, expected 0 0", k, bus.i_valid, bus.d_valid); end
      n_checks++; if (bus.i_data !== last_i || bus.d_rdata !== last_d) begin n_fail++; $display("[TB] FAIL idle_hold_%0d: got i=%h d=%h, expected %h %h", k, bus.i_data, bus.d_rdata, last_i, last_d); end
    end
  endtask

  task automatic test_overflow();
    int          cycles;
    logic [15:0] exp;
    logic [5:0]  addrs [4];
    idle_inputs();
    proc_rst = 1'b1;
    step();
    proc_rst = 1'b0;
    clear_model();
    wait_ready(cycles);
    n_checks++; if (cycles != 64) begin n_fail++; $display("[TB] FAIL ovf_clear_length: got %0d cycles, expected 64", cycles); end
    for (int k = 0; k < 70; k++) begin
      bus.load_valid = 1'b1; bus.load_data = 16'hA000 + 16'(k); bus.load_last = 1'b0;
      n_checks++; if (bus.load_ready !== (k < 64)) begin n_fail++; $display("[TB] FAIL ovf_ready_%0d: got %b, expected %b", k, bus.load_ready, (k < 64)); end
      if (k < 64) model[k] = 16'hA000 + 16'(k);
      step();
    end
    idle_inputs();
    n_checks++; if (bus.boot_done !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_boot_done: got %b, expected 1", bus.boot_done); end
    addrs = '{6'd63, 6'd0, 6'd31, 6'd62};
    for (int k = 0; k < 4; k++) begin
      bus.i_req = 1'b1; bus.i_addr = addrs[k];
      i_q.push_back(model[addrs[k]]);
      bus.d_re = 1'b1; bus.d_byte = 1'b0; bus.d_addr = {addrs[3 - k], 1'b0};
      d_q.push_back(model[addrs[3 - k]]);
      step();
      exp = i_q.pop_front(); last_i = exp;
      n_checks++; if (bus.i_valid !== 1'b1 || bus.i_data !== exp) begin n_fail++; $display("[TB] FAIL ovf_word_%0d: got v=%b %h, expected v=1 %h", addrs[k], bus.i_valid, bus.i_data, exp); end
      exp = d_q.pop_front(); last_d = exp;
      n_checks++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== exp) begin n_fail++; $display("[TB] FAIL ovf_dword_%0d: got v=%b %h, expected v=1 %h", addrs[3 - k], bus.d_valid, bus.d_rdata, exp); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_load();
    int          cycles;
    logic [15:0] exp;
    bus.i_req = 1'b1; bus.i_addr = 6'd1; bus.d_re = 1'b1; bus.d_addr = 7'd2;
    proc_rst = 1'b1;
    step();
    idle_inputs();
    proc_rst = 1'b0;
    n_checks++; if (bus.i_valid !== 1'b0 || bus.d_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_run_valids: got i=%b d=%b, expected 0 0", bus.i_valid, bus.d_valid); end
    n_checks++; if (bus.boot_done !== 1'b0 || bus.i_data !== 16'h0) begin n_fail++; $display("[TB] FAIL rst_run_state: got done=%b i=%h, expected 0 0000", bus.boot_done, bus.i_data); end
    clear_model();
    wait_ready(cycles);
    n_checks++; if (cycles != 64) begin n_fail++; $display("[TB] FAIL mid_clear1: got %0d cycles, expected 64", cycles); end
    for (int k = 0; k < 3; k++) begin
      bus.load_valid = 1'b1; bus.load_data = 16'hC000 + 16'(k);
      step();
    end
    idle_inputs();
    proc_rst = 1'b1;
    step();
    proc_rst = 1'b0;
    n_checks++; if (bus.load_ready !== 1'b0 || bus.boot_done !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_flags: got ready=%b done=%b, expected 0 0", bus.load_ready, bus.boot_done); end
    n_checks++; if (bus.i_valid !== 1'b0 || bus.d_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_valids: got i=%b d=%b, expected 0 0", bus.i_valid, bus.d_valid); end
    clear_model();
    wait_ready(cycles);
    n_checks++; if (cycles != 64) begin n_fail++; $display("[TB] FAIL mid_clear2: got %0d cycles, expected 64", cycles); end
    bus.load_valid = 1'b1; bus.load_data = 16'hD000;
    step();
    bus.load_data = 16'hD001; bus.load_last = 1'b1;
    step();
    idle_inputs();
    model[0] = 16'hD000; model[1] = 16'hD001;
    n_checks++; if (bus.boot_done !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_boot_done: got %b, expected 1", bus.boot_done); end
    for (int k = 0; k < 3; k++) begin
      bus.i_req = 1'b1; bus.i_addr = 6'(k);
      i_q.push_back(model[k]);
      bus.d_re = 1'b1; bus.d_byte = 1'b1; bus.d_signed = 1'b1; bus.d_addr = {6'(k), 1'b1};
      d_q.push_back(model_read({6'(k), 1'b1}, 1'b1, 1'b1));
      step();
      exp = i_q.pop_front(); last_i = exp;
      n_checks++; if (bus.i_valid !== 1'b1 || bus.i_data !== exp) begin n_fail++; $display("[TB] FAIL mid_word_%0d: got v=%b %h, expected v=1 %h", k, bus.i_valid, bus.i_data, exp); end
      exp = d_q.pop_front(); last_d = exp;
      n_checks++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== exp) begin n_fail++; $display("[TB] FAIL mid_byte_%0d: got v=%b %h, expected v=1 %h", k, bus.d_valid, bus.d_rdata, exp); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load();
    test_ifetch();
    test_byte();
    test_collision();
    test_idle();
    test_overflow();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
